// File: rtl/store_buffer.sv
// In-order store buffer: circular queue of committed stores drained over a valid/ready
// write port, with a same-cycle load lookup. Define STORE_BUFFER_FORWARD_EN to enable forwarding.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      push_addr,
  input  logic [31:0]            push_val,
  input  logic [1:0]             push_size,
  input  logic                   push_valid,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   push_misaligned,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [31:0]            mem_val,
  output logic [3:0]             mem_strb,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  input  logic [ADDR_W-1:0]      lookup_addr,
  input  logic [1:0]             lookup_size,
  output logic                   lookup_hit,
  output logic [31:0]            lookup_data,
  output logic                   lookup_conflict
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WA = ADDR_W - 2;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      2'd2:    return lo != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return 4'b0011 << lo;
      default: return 4'hF;
    endcase
  endfunction

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic           mis_q, mis_d;
  logic [WA-1:0]  waddr_q [DEPTH];
  logic [31:0]    data_q  [DEPTH];
  logic [3:0]     strb_q  [DEPTH];

  logic push_mis, push_acc, pop;
  logic [3:0] l_mask;
  logic       l_mis;
  logic       any_ov;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign mem_valid = !empty;
  assign push_misaligned = mis_q;

  assign push_mis = push_valid && !full && is_misaligned(push_size, push_addr[1:0]);
  assign push_acc = push_valid && !full && !is_misaligned(push_size, push_addr[1:0]);
  assign pop      = !empty && mem_ready;

  // Head entry is gated to zero when empty so the write port idles cleanly.
  assign mem_addr = empty ? '0 : {waddr_q[rd_ptr_q], 2'b00};
  assign mem_val  = empty ? '0 : data_q[rd_ptr_q];
  assign mem_strb = empty ? '0 : strb_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q;
    mis_d    = push_mis;
    if (pop) begin
      rd_ptr_d        = rd_ptr_q + PW'(1);
      vld_d[rd_ptr_q] = 1'b0;
    end
    if (push_acc) begin
      wr_ptr_d        = wr_ptr_q + PW'(1);
      vld_d[wr_ptr_q] = 1'b1;
    end
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      mis_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      mis_q    <= mis_d;
    end
  end

  // Payload needs no reset: every reader is qualified by vld_q or empty.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      waddr_q[wr_ptr_q] <= push_addr[ADDR_W-1:2];
      data_q[wr_ptr_q]  <= push_val << {push_addr[1:0], 3'b000};
      strb_q[wr_ptr_q]  <= byte_mask(push_size, push_addr[1:0]);
    end
  end

  assign l_mask = byte_mask(lookup_size, lookup_addr[1:0]);
  assign l_mis  = is_misaligned(lookup_size, lookup_addr[1:0]);

`ifdef STORE_BUFFER_FORWARD_EN
  function automatic logic [31:0] size_keep(input logic [1:0] size);
    case (size)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  logic [PW-1:0] idx;
  logic [3:0]    sel_mask;
  logic [31:0]   sel_data;

  // Walk oldest to youngest so the last overlapping entry seen is the youngest.
  always_comb begin
    idx      = '0;
    any_ov   = 1'b0;
    sel_mask = '0;
    sel_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (!l_mis && vld_q[idx] && waddr_q[idx] == lookup_addr[ADDR_W-1:2]
          && (strb_q[idx] & l_mask) != 4'h0) begin
        any_ov   = 1'b1;
        sel_mask = strb_q[idx];
        sel_data = data_q[idx];
      end
    end
    lookup_hit      = any_ov && ((sel_mask & l_mask) == l_mask);
    lookup_data     = (sel_data >> {lookup_addr[1:0], 3'b000}) & size_keep(lookup_size);
    lookup_conflict = any_ov && !lookup_hit;
  end
`else
  always_comb begin
    any_ov = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && waddr_q[i] == lookup_addr[ADDR_W-1:2] && (strb_q[i] & l_mask) != 4'h0)
        any_ov = 1'b1;
    end
    if (l_mis) any_ov = 1'b0;
    lookup_hit      = 1'b0;
    lookup_data     = '0;
    lookup_conflict = any_ov;
  end
`endif

endmodule

// File: doc/store_buffer.md
# store_buffer

Parametrised in-order store buffer between the commit stage and the data-bus write port. It replaces the fixed external data FIFO with a configurable-depth circular buffer and drains committed stores to memory through a valid/ready handshake. It also gives the execute stage a same-cycle address lookup, so a load either forwards data from the youngest matching store or stalls on a partial overlap.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- ADDR_W, 32: address width; bits [1:0] select the byte lane.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- push_addr  in  ADDR_W  store byte address from commit.
- push_val  in  32  store data, right-justified.
- push_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and is treated as misaligned.
- push_valid  in  1  store request; accepted when `full`=0.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- push_misaligned  out  1  one-cycle pulse when a misaligned push is dropped.
- mem_addr  out  ADDR_W  head entry address, word-aligned (bits [1:0] = 0).
- mem_val  out  32  head entry data, lane-aligned.
- mem_strb  out  4  head entry byte-enable mask.
- mem_valid  out  1  head entry present (= !empty).
- mem_ready  in  1  memory accepts the head entry.
- lookup_addr  in  ADDR_W  load byte address from execute.
- lookup_size  in  2  load size, same encoding as push_size.
- lookup_hit  out  1  load is fully forwarded (combinational).
- lookup_data  out  32  forwarded bytes, right-justified and zero-extended.
- lookup_conflict  out  1  load must stall (combinational).

## Operation
- Each entry holds {word address, lane-aligned data, 4-bit byte mask}.
  - Mask: byte = 1<<a[1:0]; half = 3<<a[1:0]; word = 4'hF.
  - Data is shifted left by 8*a[1:0].
- Misaligned push (half with a[0]=1, word with a[1:0]≠0, or size 3): the entry is not written and `push_misaligned` pulses on the next cycle. Commit raises the exception.
- Push: accepted when push_valid && !full. Writes the entry at wr_ptr; wr_ptr increments modulo DEPTH.
  - A push while full is ignored, even if a pop occurs in the same cycle. Commit must hold the request.
- Pop: occurs when mem_valid && mem_ready. rd_ptr increments modulo DEPTH.
  - mem_* outputs are driven from the head entry and stay stable while mem_ready=0.
- Count update: push only = +1; pop only = −1; both = unchanged.
- Lookup (evaluated every cycle):
  - Overlap: a valid entry has the same word address as lookup_addr and a mask that intersects the lookup mask.
  - Entries are ranked by age from rd_ptr. The youngest overlapping entry is selected.
  - lookup_hit: the selected entry's mask covers the whole lookup mask.
  - lookup_data: the selected entry's data shifted right by 8*lookup_addr[1:0], with bytes above the lookup size zeroed.
  - lookup_conflict = any overlap && !lookup_hit.
  - A misaligned lookup returns hit = 0 and conflict = 0. The alignment exception is raised by execute.
- Visibility: an entry pushed in cycle N is visible to lookups from N+1. An entry popping in cycle N is still visible in cycle N.

## Timing
- Reset values: full 0, empty 1, count 0, mem_valid 0, mem_addr/mem_val/mem_strb 0, push_misaligned 0, both pointers 0, all entries invalid.
- Reset asserted mid-operation discards every entry immediately; nothing is drained.
- Latency:
  - Push in cycle N appears on mem_* in cycle N+1 when the buffer was empty.
  - Minimum push-to-pop is 1 cycle.
  - Throughput is one push and one pop per cycle.
- full, empty and count reflect registered state only, with no combinational path from push_valid or mem_ready.
- The lookup path is purely combinational from lookup_* and stored state.

## Configuration
- STORE_BUFFER_FORWARD_EN defined: forwarding operates as described under Operation.
- Not defined:
  - lookup_hit = 0 and lookup_data = 0.
  - lookup_conflict = any overlap, so every overlapping load stalls until the matching entries drain.
  - The age-select and shift logic are removed.

## Test plan
- Reset, then push word 0x1000/0xDEADBEEF with mem_ready=0 → next cycle: mem_valid=1, mem_addr=0x1000, mem_strb=4'hF, count=1. Entry holds until mem_ready=1, then empty=1 on the following cycle.
- DEPTH=4: push 5 words back-to-back with mem_ready=0 → full=1 after the 4th, the 5th is ignored, count=4. Then mem_ready=1 drains in order, the pointers wrap, and 4 further pushes are accepted.
- Push byte 0x1003/0xAB, then look up byte 0x1003 → hit=1, data=0x000000AB (with FORWARD_EN). Look up word 0x1000 → conflict=1, hit=0.
- Push word 0x2000/0x11223344, then half 0x2002/0xBEEF; look up half 0x2002 → data=0x0000BEEF (youngest entry wins). Look up half 0x2000 → data=0x00003344.
- Push half at 0x3001 → no entry written, push_misaligned=1 for exactly one cycle, count unchanged.
- Simultaneous push and pop at count=2 → count stays 2. Assert reset mid-drain → empty=1 and mem_valid=0 immediately.
